// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer: one RTC bus transaction per request on the multiplexed
// address/data interface. A transaction runs address phase, CS_n-high gap,
// then data phase. Every output is a register loaded from the next-state
// decode, so the strobes line up with the state they belong to.
module rtc_bus_sequencer #(
    parameter int T_SETUP  = 2,
    parameter int T_STROBE = 4,
    parameter int T_HOLD   = 2,
    parameter int T_GAP    = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ_WR,
    input  logic       REQ_RD,
    input  logic [7:0] ADDR_IN,
    output logic [7:0] ADRESS,
    output logic       BEnv_Adress,
    output logic       BEnv_Data,
    output logic       BRes_Data,
    output logic       CS_n,
    output logic       AD,
    output logic       WR_n,
    output logic       RD_n,
    output logic       BUSY,
    output logic       DONE
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_A_SETUP  = 4'd1,
        S_A_STROBE = 4'd2,
        S_A_HOLD   = 4'd3,
        S_GAP      = 4'd4,
        S_D_SETUP  = 4'd5,
        S_D_STROBE = 4'd6,
        S_D_HOLD   = 4'd7,
        S_DONE     = 4'd8
    } state_t;

    // Counter load values: each phase lasts (load + 1) cycles.
    localparam logic [7:0] LD_SETUP  = 8'(T_SETUP - 1);
    localparam logic [7:0] LD_STROBE = 8'(T_STROBE - 1);
    localparam logic [7:0] LD_HOLD   = 8'(T_HOLD - 1);
    localparam logic [7:0] LD_GAP    = 8'(T_GAP - 1);

    state_t     state_r;
    state_t     state_s;
    logic [7:0] cnt_r;
    logic [7:0] cnt_s;
    logic       op_wr_r;
    logic       op_wr_s;
    logic [7:0] addr_s;

    logic       cs_n_s;
    logic       ad_s;
    logic       wr_n_s;
    logic       rd_n_s;
    logic       benv_a_s;
    logic       benv_d_s;
    logic       bres_s;
    logic       busy_s;
    logic       done_s;

    // Next-state, phase counter and request latching.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        op_wr_s = op_wr_r;
        addr_s  = ADRESS;
        case (state_r)
            S_IDLE: begin
                if (REQ_WR || REQ_RD) begin
                    state_s = S_A_SETUP;
                    cnt_s   = LD_SETUP;
                    op_wr_s = REQ_WR;
                    addr_s  = ADDR_IN;
                end else begin
                    cnt_s   = 8'd0;
                end
            end
            S_A_SETUP, S_A_STROBE, S_A_HOLD, S_GAP,
            S_D_SETUP, S_D_STROBE, S_D_HOLD: begin
                if (cnt_r != 8'd0) begin
                    cnt_s = cnt_r - 8'd1;
                end else begin
                    case (state_r)
                        S_A_SETUP:  begin state_s = S_A_STROBE; cnt_s = LD_STROBE; end
                        S_A_STROBE: begin state_s = S_A_HOLD;   cnt_s = LD_HOLD;   end
                        S_A_HOLD:   begin state_s = S_GAP;      cnt_s = LD_GAP;    end
                        S_GAP:      begin state_s = S_D_SETUP;  cnt_s = LD_SETUP;  end
                        S_D_SETUP:  begin state_s = S_D_STROBE; cnt_s = LD_STROBE; end
                        S_D_STROBE: begin state_s = S_D_HOLD;   cnt_s = LD_HOLD;   end
                        S_D_HOLD:   begin state_s = S_DONE;     cnt_s = 8'd0;      end
                        default:    begin state_s = S_IDLE;     cnt_s = 8'd0;      end
                    endcase
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
                cnt_s   = 8'd0;
            end
            default: begin
                state_s = S_IDLE;
                cnt_s   = 8'd0;
            end
        endcase
    end

    // Output decode from the upcoming state/count so registered outputs match it.
    always_comb begin
        cs_n_s   = 1'b1;
        ad_s     = 1'b1;
        wr_n_s   = 1'b1;
        rd_n_s   = 1'b1;
        benv_a_s = 1'b0;
        benv_d_s = 1'b0;
        bres_s   = 1'b0;
        busy_s   = 1'b0;
        done_s   = 1'b0;
        case (state_s)
            S_A_SETUP, S_A_HOLD: begin
                cs_n_s   = 1'b0;
                ad_s     = 1'b0;
                benv_a_s = 1'b1;
                busy_s   = 1'b1;
            end
            S_A_STROBE: begin
                cs_n_s   = 1'b0;
                ad_s     = 1'b0;
                benv_a_s = 1'b1;
                wr_n_s   = 1'b0;
                busy_s   = 1'b1;
            end
            S_GAP: begin
                busy_s = 1'b1;
            end
            S_D_SETUP: begin
                cs_n_s   = 1'b0;
                busy_s   = 1'b1;
                benv_d_s = op_wr_s;
            end
            S_D_STROBE: begin
                cs_n_s = 1'b0;
                busy_s = 1'b1;
                if (op_wr_s) begin
                    benv_d_s = 1'b1;
                    wr_n_s   = 1'b0;
                end else begin
                    rd_n_s = 1'b0;
                    bres_s = (cnt_s == 8'd0);
                end
            end
            S_D_HOLD: begin
                cs_n_s = 1'b0;
                busy_s = 1'b1;
                if (op_wr_s) begin
                    benv_d_s = 1'b1;
                end else begin
                    // Read strobe stretches into the first hold cycle.
                    rd_n_s = (cnt_s != LD_HOLD);
                end
            end
            S_DONE: begin
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // State, counter and latched operation register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= S_IDLE;
            cnt_r   <= 8'd0;
            op_wr_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            op_wr_r <= op_wr_s;
        end
    end

    // Registered chip strobes, phase flags and status.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ADRESS      <= 8'h00;
            CS_n        <= 1'b1;
            AD          <= 1'b1;
            WR_n        <= 1'b1;
            RD_n        <= 1'b1;
            BEnv_Adress <= 1'b0;
            BEnv_Data   <= 1'b0;
            BRes_Data   <= 1'b0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
        end else begin
            ADRESS      <= addr_s;
            CS_n        <= cs_n_s;
            AD          <= ad_s;
            WR_n        <= wr_n_s;
            RD_n        <= rd_n_s;
            BEnv_Adress <= benv_a_s;
            BEnv_Data   <= benv_d_s;
            BRes_Data   <= bres_s;
            BUSY        <= busy_s;
            DONE        <= done_s;
        end
    end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Testbench for rtc_bus_sequencer: timeline model of a transaction checked
// every cycle, plus directed scenarios with hand-computed counts.
module tb_rtc_bus_sequencer;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       REQ_WR = 1'b0;
    logic       REQ_RD = 1'b0;
    logic [7:0] ADDR_IN = 8'h00;
    logic [7:0] ADRESS;
    logic       BEnv_Adress, BEnv_Data, BRes_Data;
    logic       CS_n, AD, WR_n, RD_n, BUSY, DONE;

    int errors = 0;
    int checks = 0;

    rtc_bus_sequencer dut (
        .CLK(CLK), .RST(RST), .REQ_WR(REQ_WR), .REQ_RD(REQ_RD),
        .ADDR_IN(ADDR_IN), .ADRESS(ADRESS), .BEnv_Adress(BEnv_Adress),
        .BEnv_Data(BEnv_Data), .BRes_Data(BRes_Data), .CS_n(CS_n),
        .AD(AD), .WR_n(WR_n), .RD_n(RD_n), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    // Simple RTC: drives its register value while RD_n is low; the
    // Multiplexado-side capture register takes the bus when BRes_Data is high.
    logic [7:0] rtc_bus;
    logic [7:0] segundos_t = 8'h00;
    assign rtc_bus = RD_n ? 8'h00 : 8'h15;
    always @(posedge CLK) if (BRes_Data) segundos_t <= rtc_bus;

    logic [16:0] outs;
    assign outs = {ADRESS, BEnv_Adress, BEnv_Data, BRes_Data, CS_n, AD, WR_n, RD_n, BUSY, DONE};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: mt = cycles since accept (1..19 bus cycle, 20 = DONE), 0 = idle.
    int         mt = 0;
    logic       m_wr = 1'b0;
    logic [7:0] m_addr = 8'h00;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            mt = 0; m_addr = 8'h00; m_wr = 1'b0;
        end else if (mt == 0) begin
            if (REQ_WR || REQ_RD) begin
                mt = 1; m_wr = REQ_WR; m_addr = ADDR_IN;
            end
        end else if (mt == 20) begin
            mt = 0;
        end else begin
            mt++;
        end
    end

    function automatic logic [16:0] exp_vec();
        logic cs, ad, wr, rd, ba, bd, br, busy, done;
        int d;
        cs = 1'b1; ad = 1'b1; wr = 1'b1; rd = 1'b1;
        ba = 1'b0; bd = 1'b0; br = 1'b0;
        busy = (mt >= 1 && mt <= 19);
        done = (mt == 20);
        if (mt >= 1 && mt <= 8) begin
            cs = 1'b0; ad = 1'b0; ba = 1'b1;
            wr = !(mt >= 3 && mt <= 6);
        end
        if (mt >= 12 && mt <= 19) begin
            d = mt - 11;
            cs = 1'b0;
            if (m_wr) begin
                bd = 1'b1;
                wr = !(d >= 3 && d <= 6);
            end else begin
                rd = !(d >= 3 && d <= 7);
                br = (d == 6);
            end
        end
        return {m_addr, ba, bd, br, cs, ad, wr, rd, busy, done};
    endfunction

    bit cmp_en = 1'b0;

    // Per-cycle comparison against the model.
    always @(negedge CLK) begin
        if (cmp_en) begin
            chk("cycle", {15'd0, outs}, {15'd0, exp_vec()});
            if (BEnv_Adress && BEnv_Data) chk("flag_excl", 32'd1, 32'd0);
        end
    end

    task automatic run_txn(input logic wr, input logic rd, input logic [7:0] addr,
                           input logic [7:0] addr_mid, output int done_cyc,
                           output int ad_low, output int wr_low, output int rd_low,
                           output int gap, output int bres);
        @(posedge CLK); #2;
        REQ_WR = wr; REQ_RD = rd; ADDR_IN = addr;
        @(posedge CLK); #2;
        REQ_WR = 1'b0; REQ_RD = 1'b0; ADDR_IN = addr_mid;
        done_cyc = -1; ad_low = 0; wr_low = 0; rd_low = 0; gap = 0; bres = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (!AD) ad_low++;
            if (!WR_n) wr_low++;
            if (!RD_n) rd_low++;
            if (CS_n && BUSY) gap++;
            if (BRes_Data) bres++;
            if (DONE) begin
                done_cyc = c;
                break;
            end
        end
    endtask

    task automatic wait_done(input string nm);
        int c;
        for (c = 0; c < 60; c++) begin
            @(negedge CLK);
            if (DONE) break;
        end
        chk(nm, (c < 60) ? 32'd1 : 32'd0, 32'd1);
    endtask

    int dc, adl, wrl, rdl, gp, br, idle;

    initial begin
        #1 RST = 1'b1;
        #2 chk("reset_state", {15'd0, outs}, 32'h0003C);
        cmp_en = 1'b1;
        repeat (2) @(posedge CLK);
        #2 RST = 1'b0;
        repeat (2) @(negedge CLK);

        // Write to 0x23: timing counts.
        run_txn(1'b1, 1'b0, 8'h23, 8'h23, dc, adl, wrl, rdl, gp, br);
        chk("wr_latency", dc, 32'd19);
        chk("wr_ad_low", adl, 32'd8);
        chk("wr_gap", gp, 32'd3);
        chk("wr_wr_low", wrl, 32'd8);
        chk("wr_adress", {24'd0, ADRESS}, 32'h23);

        // Read from 0x41: single BRes pulse, captured 0x15.
        segundos_t = 8'h00;
        run_txn(1'b0, 1'b1, 8'h41, 8'h41, dc, adl, wrl, rdl, gp, br);
        @(negedge CLK);
        chk("rd_latency", dc, 32'd19);
        chk("rd_bres_pulses", br, 32'd1);
        chk("rd_rd_low", rdl, 32'd5);
        chk("rd_wr_low", wrl, 32'd4);
        chk("rd_captured", {24'd0, segundos_t}, 32'h15);

        // Simultaneous write and read: write wins.
        run_txn(1'b1, 1'b1, 8'h0F, 8'h0F, dc, adl, wrl, rdl, gp, br);
        chk("both_rd_low", rdl, 32'd0);
        chk("both_wr_low", wrl, 32'd8);
        chk("both_bres", br, 32'd0);

        // Address toggled while busy: latched value holds.
        run_txn(1'b1, 1'b0, 8'h26, 8'h00, dc, adl, wrl, rdl, gp, br);
        chk("toggle_adress", {24'd0, ADRESS}, 32'h26);
        @(negedge CLK);
        chk("toggle_adress_idle", {24'd0, ADRESS}, 32'h26);

        // REQ_RD held: exactly one idle cycle between transactions.
        @(posedge CLK); #2;
        REQ_RD = 1'b1; ADDR_IN = 8'h30;
        for (int k = 0; k < 2; k++) begin
            wait_done("hold_done");
            idle = 0;
            for (int c = 0; c < 10; c++) begin
                @(negedge CLK);
                if (BUSY) break;
                if (!DONE) idle++;
            end
            chk("hold_idle_cycles", idle, 32'd1);
        end
        REQ_RD = 1'b0;
        wait_done("hold_last_done");
        repeat (2) @(negedge CLK);

        // Reset in the middle of a write data strobe.
        @(posedge CLK); #2;
        REQ_WR = 1'b1; ADDR_IN = 8'h5A;
        @(posedge CLK); #2;
        REQ_WR = 1'b0;
        repeat (15) @(negedge CLK);
        chk("pre_rst_wr_n", {31'd0, WR_n}, 32'd0);
        #2 RST = 1'b1;
        #1 chk("rst_async", {29'd0, CS_n, WR_n, BEnv_Data}, 32'h6);
        repeat (2) @(negedge CLK);
        @(posedge CLK); #2 RST = 1'b0;
        repeat (3) @(negedge CLK);
        chk("post_rst_idle", {15'd0, outs}, 32'h0003C);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
